// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: SYNC/CMD/ADDR/DATA[/CSUM] frames to single register
// accesses with a one-byte response. Define UART_CMD_CSUM_EN to add the XOR checksum byte.
module uart_cmd_ctrl #(
  parameter logic [7:0] SyncByte      = 8'hA5,
  parameter int         TimeoutCycles = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_ready,
  output logic       o_reg_wr,
  output logic       o_reg_rd,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic [7:0] i_reg_rdata,
  input  logic       i_reg_ack,
  output logic       o_busy,
  output logic       o_err
);

  localparam int              CntW     = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(TimeoutCycles);
  localparam logic [7:0]      CmdWrite = 8'h01;
  localparam logic [7:0]      CmdRead  = 8'h02;
  localparam logic [7:0]      RespAck  = 8'h4B;
  localparam logic [7:0]      RespErr  = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
`ifdef UART_CMD_CSUM_EN
    S_CSUM,
`endif
    S_EXEC,
    S_WAIT_RD,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      resp_q, resp_d;
  logic            in_frame;
  logic            frame_ok;
`ifdef UART_CMD_CSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
`ifdef UART_CMD_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
`ifdef UART_CMD_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    in_frame = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA)
`ifdef UART_CMD_CSUM_EN
               || (state_q == S_CSUM)
`endif
               ;
`ifdef UART_CMD_CSUM_EN
    frame_ok = (csum_q == (cmd_q ^ addr_q ^ data_q));
`else
    frame_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    resp_d   = resp_q;
`ifdef UART_CMD_CSUM_EN
    csum_d   = csum_q;
`endif
    o_reg_wr = 1'b0;
    o_reg_rd = 1'b0;
    o_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_byte == SyncByte)) state_d = S_CMD;
      end
      S_CMD: begin
        if (i_rx_valid) begin
          cmd_d   = i_rx_byte;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_rx_valid) begin
          addr_d  = i_rx_byte;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_rx_valid) begin
          data_d  = i_rx_byte;
`ifdef UART_CMD_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_EXEC;
`endif
        end
      end
`ifdef UART_CMD_CSUM_EN
      S_CSUM: begin
        if (i_rx_valid) begin
          csum_d  = i_rx_byte;
          state_d = S_EXEC;
        end
      end
`endif
      S_EXEC: begin
        if (frame_ok && (cmd_q == CmdWrite)) begin
          o_reg_wr = 1'b1;
          resp_d   = RespAck;
          state_d  = S_RESP;
        end else if (frame_ok && (cmd_q == CmdRead)) begin
          o_reg_rd = 1'b1;
          state_d  = S_WAIT_RD;
        end else begin
          o_err    = 1'b1;
          resp_d   = RespErr;
          state_d  = S_RESP;
        end
      end
      S_WAIT_RD: begin
        // A same-cycle ack beats the timeout.
        if (i_reg_ack) begin
          resp_d  = i_reg_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CntMax) begin
          o_err   = 1'b1;
          resp_d  = RespErr;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      S_RESP: begin
        if (i_tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Interbyte timeout: an accepted byte always changes state, so the count restarts.
    if (in_frame && !i_rx_valid) begin
      if (cnt_q == CntMax) state_d = S_IDLE;
      else                 cnt_d   = cnt_q + CntW'(1);
    end
  end

  assign o_tx_valid  = (state_q == S_RESP);
  assign o_tx_byte   = resp_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = data_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed and randomized frames for uart_cmd_ctrl, checked against expected responses
// derived from the frame rules (command decode, read data, timeouts, backpressure).
module tb_uart_cmd_ctrl;

  localparam int T = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       busy;
  logic       err;

  uart_cmd_ctrl #(.SyncByte(8'hA5), .TimeoutCycles(T)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_tx_valid(tx_valid), .o_tx_byte(tx_byte), .i_tx_ready(tx_ready),
    .o_reg_wr(reg_wr), .o_reg_rd(reg_rd), .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
    .i_reg_rdata(reg_rdata), .i_reg_ack(reg_ack),
    .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int txv_cnt = 0;
  logic [7:0] wr_addr_seen = 8'h00;
  logic [7:0] wr_data_seen = 8'h00;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt++;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wdata;
    end
    if (reg_rd)   rd_cnt++;
    if (err)      err_cnt++;
    if (tx_valid) txv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input int gap, input logic [7:0] csum_flip);
    logic [7:0] q[$];
    q = '{8'hA5, cmd, addr, data};
`ifdef UART_CMD_CSUM_EN
    q.push_back(cmd ^ addr ^ data ^ csum_flip);
`endif
    foreach (q[i]) begin
      send_byte(q[i]);
      if (i != q.size() - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_tx(input int budget, output int waited);
    waited = 0;
    while (!tx_valid && waited < budget) begin
      tick();
      waited++;
    end
    chk("tx_valid_within_budget", 32'(tx_valid), 32'd1);
  endtask

  // One complete frame: send, serve the bus, check response, then release it.
  // ack_dly < 0 means the read is never acknowledged.
  task automatic do_txn(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                        input int gap, input bit bad_csum, input int ack_dly,
                        input logic [7:0] rdata, input int rdy_dly);
    int         wr0, rd0, err0, w;
    bit         known, is_wr, is_rd, exp_err;
    logic [7:0] exp;
    wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt;
    known   = ((cmd == 8'h01) || (cmd == 8'h02)) && !bad_csum;
    is_wr   = known && (cmd == 8'h01);
    is_rd   = known && (cmd == 8'h02);
    exp_err = !known || (is_rd && ack_dly < 0);

    send_frame(cmd, addr, data, gap, bad_csum ? 8'h01 : 8'h00);
    chk("exec_wr_strobe", 32'(reg_wr), 32'(is_wr));
    chk("exec_rd_strobe", 32'(reg_rd), 32'(is_rd));
    chk("exec_err_pulse", 32'(err), 32'(!known));

    if (is_rd) begin
      tick();
      if (ack_dly >= 0) begin
        repeat (ack_dly) tick();
        reg_rdata = rdata;
        reg_ack   = 1'b1;
        tick();
        reg_ack   = 1'b0;
        reg_rdata = 8'($urandom);
        chk("rd_ack_to_tx_latency", 32'(tx_valid), 32'd1);
        exp = rdata;
      end else begin
        wait_tx(T + 50, w);
        chk("rd_timeout_window", 32'((w >= T) && (w <= T + 2)), 32'd1);
        exp = 8'h45;
      end
    end else begin
      tick();
      chk("exec_to_tx_latency", 32'(tx_valid), 32'd1);
      exp = is_wr ? 8'h4B : 8'h45;
    end
    chk("resp_byte", 32'(tx_byte), 32'(exp));

    repeat (rdy_dly) begin
      if ($urandom_range(0, 1) == 1) begin
        rx_valid = 1'b1;
        rx_byte  = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom);
      end
      tick();
      rx_valid = 1'b0;
      chk("resp_hold_valid", 32'(tx_valid), 32'd1);
      chk("resp_hold_byte", 32'(tx_byte), 32'(exp));
    end
    tx_ready = 1'b1;
    rx_valid = 1'($urandom_range(0, 1));
    rx_byte  = 8'hA5;
    tick();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    chk("idle_after_accept", 32'(busy), 32'd0);
    chk("tx_valid_after_accept", 32'(tx_valid), 32'd0);

    chk("wr_strobe_count", 32'(wr_cnt - wr0), 32'(is_wr));
    chk("rd_strobe_count", 32'(rd_cnt - rd0), 32'(is_rd));
    chk("err_pulse_count", 32'(err_cnt - err0), 32'(exp_err));
    chk("addr_held", 32'(reg_addr), 32'(addr));
    if (is_wr) begin
      chk("wr_addr", 32'(wr_addr_seen), 32'(addr));
      chk("wr_data", 32'(wr_data_seen), 32'(data));
    end
    $display("txn cmd=%02h addr=%02h data=%02h bad=%0d -> resp=%02h", cmd, addr, data, bad_csum, exp);
  endtask

  initial begin
    int         txv0;
    logic [7:0] c, g;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b0;
    reg_rdata = 8'h00; reg_ack = 1'b0;
    repeat (3) tick();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_reg_rd", 32'(reg_rd), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    do_txn(8'h01, 8'h10, 8'h3C, 0, 1'b0, 0, 8'h00, 5);
    do_txn(8'h02, 8'h20, 8'h00, 0, 1'b0, 3, 8'h99, 2);
    do_txn(8'h02, 8'h21, 8'h00, 1, 1'b0, 0, 8'h5A, 0);
    do_txn(8'h07, 8'h30, 8'h11, 0, 1'b0, 0, 8'h00, 1);
`ifdef UART_CMD_CSUM_EN
    do_txn(8'h01, 8'h40, 8'h22, 0, 1'b1, 0, 8'h00, 1);
`endif

    // Interbyte timeout leaves silently; the next frame still works.
    txv0 = txv_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (T - 5) tick();
    chk("timeout_still_busy", 32'(busy), 32'd1);
    repeat (10) tick();
    chk("timeout_back_idle", 32'(busy), 32'd0);
    chk("timeout_no_response", 32'(txv_cnt - txv0), 32'd0);
    $display("txn interbyte timeout busy=%0d", busy);
    do_txn(8'h01, 8'h55, 8'hAA, 0, 1'b0, 0, 8'h00, 0);

    do_txn(8'h02, 8'h60, 8'h00, 0, 1'b0, -1, 8'h00, 0);
    do_txn(8'h01, 8'h70, 8'h0F, 0, 1'b0, 0, 8'h00, 50);

    // Reset during RESP.
    send_frame(8'h01, 8'h80, 8'h81, 0, 8'h00);
    tick();
    chk("pre_reset_tx_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    send_byte(8'h3C);
    chk("garbage_ignored", 32'(busy), 32'd0);
    $display("txn reset mid-resp tx_valid=%0d busy=%0d", tx_valid, busy);

    for (int n = 0; n < 20; n++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h00;
      send_byte(g);
      chk("rand_garbage_ignored", 32'(busy), 32'd0);
      case ($urandom_range(0, 3))
        0:       c = 8'h01;
        1:       c = 8'h02;
        2:       c = 8'h07;
        default: c = 8'h80 | 8'($urandom);
      endcase
      do_txn(c, 8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0,
             $urandom_range(0, 4), 8'($urandom), $urandom_range(0, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
